id_beacon_tx: RTL and testbench
===============================

# id_beacon_tx

Serial transmitter that announces this board's locked ID to peer boards over a single open-line wire. It is the sending end of the ID-arbitration link: peers decode the beacon into their `external_ID_1`/`external_ID_2` inputs. It sits next to the ID-assignment logic and consumes its `board_ID` output once the ID is locked. Beacons are sent on ID lock, periodically while locked, and on demand.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (115200 baud at 100 MHz); minimum 2.
- `BEACON_PERIOD`, 1_000_000, cycles between periodic beacons while locked; minimum 16×`CLKS_PER_BIT`.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `board_id` input 2: locked board ID; 2'b00 = unassigned.
- `id_valid` input 1: high while `board_id` is locked.
- `force_send` input 1: one-cycle request for an immediate beacon.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: high while a frame is on the line.
- `frame_done` output 1: one-cycle pulse at end of each frame.

## Operation
- Frame: 10 bits, no parity: start (0), 8 data bits LSB first, stop (1).
- Data byte: [7:4]=4'hA marker, [3:2]=~id, [1:0]=id; id=01 → 0xA9, 10 → 0xA6, 11 → 0xA3.
- `id` is captured at frame start; `board_id` changes mid-frame do not affect the frame in flight.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when `pending` is set and the current `board_id` ≠ 00; clears `pending`, latches the byte.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits; a 3-bit index selects the bit.
  - STOP → IDLE after `CLKS_PER_BIT` cycles, pulsing `frame_done`.
- `pending` is a single flag. It is set by:
  - the rising edge of `id_valid` (registered previous value);
  - the period counter reaching `BEACON_PERIOD-1`;
  - `force_send` while `id_valid` is high.
- Multiple requests before service coalesce into one frame. A request during a frame sets `pending`, and the next frame follows directly after STOP, with one IDLE cycle.
- Period counter: runs only while `id_valid` is high, wraps to 0 on tick, and is held at 0 while `id_valid` is low.
- `id_valid` low or `board_id`=00 while `pending` is set: `pending` is cleared and no frame is sent.
- `id_valid` falling mid-frame: the current frame completes normally; no further beacons are sent.
- `force_send` while `id_valid` is low is ignored.
- Reset mid-frame: `tx` returns high on the next edge and all state is cleared. The line may see a truncated frame; receivers treat this as a framing error.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `frame_done`=0;
  - FSM=IDLE, `pending`=0;
  - bit counter, bit index and period counter = 0;
  - `id_valid` history = 0.
- Request at edge N (`pending` set) → IDLE samples it at edge N+1 → `tx`=0 and `busy`=1 from edge N+2.
- Each bit holds exactly `CLKS_PER_BIT` cycles. The frame occupies 10×`CLKS_PER_BIT` cycles of `busy`=1.
- `frame_done` is high for the single cycle in which the FSM returns to IDLE; `busy` is 0 in that same cycle.
- Back-to-back frames: minimum gap between stop-bit end and the next start bit is 1 cycle.
- Period ticks are independent of frame activity; a tick during a frame is not lost.

## Test plan
- CLKS_PER_BIT=4, id_valid rises with board_id=01 → `tx` sequence 0,1,0,0,1,0,1,0,1,1 (each 4 cycles); 40 cycles of `busy`; one `frame_done` pulse.
- board_id=10, force_send pulsed three times during a frame → exactly one extra frame, byte 0xA6, starting 1 cycle after `frame_done`.
- BEACON_PERIOD=200, CLKS_PER_BIT=4, id_valid held high for 1000 cycles → frames start at 200-cycle spacing after the initial one; 6 frames in total.
- id_valid high with board_id=00 → `tx` stays 1, `busy` stays 0; force_send is also ignored.
- id_valid dropped at bit 3 of a frame → frame completes, `frame_done` pulses, and no frame follows over 2×BEACON_PERIOD.
- rst_n low for 1 cycle during DATA → next edge `tx`=1, `busy`=0; after release, a new beacon is sent only on a fresh request.

Source files
------------

// File: rtl/id_beacon_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_beacon_tx : 8N1 serial beacon announcing the locked board ID    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module id_beacon_tx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int BEACON_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] board_id,
  input  logic       id_valid,
  input  logic       force_send,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_PER_W = (BEACON_PERIOD > 2) ? $clog2(BEACON_PERIOD) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(BEACON_PERIOD - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_byte;
  logic               r_pending;
  logic               r_id_valid_d;
  logic [c_PER_W-1:0] r_period_cnt;
  logic               r_tx;
  logic               r_busy;
  logic               r_frame_done;

  logic w_id_ok;
  logic w_bit_end;
  logic w_tick;
  logic w_req;
  logic w_tx_next;

  assign w_id_ok   = id_valid && (board_id != 2'b00);
  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);
  assign w_tick    = id_valid && r_id_valid_d && (r_period_cnt == c_PER_LAST);
  assign w_req     = (id_valid && !r_id_valid_d) || w_tick || (force_send && id_valid);

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      c_START: w_tx_next = 1'b0;
      c_DATA:  w_tx_next = r_byte[r_bit_idx];
      default: w_tx_next = 1'b1;
    endcase
  end

  // Counting starts the cycle after the rising edge so periodic beacons
  // land exactly BEACON_PERIOD cycles after the lock beacon.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id_valid_d <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_id_valid_d <= id_valid;
      if (!id_valid || !r_id_valid_d) begin
        r_period_cnt <= '0;
      end else if (r_period_cnt == c_PER_LAST) begin
        r_period_cnt <= '0;
      end else begin
        r_period_cnt <= r_period_cnt + c_PER_W'(1);
      end
    end
  end

  // A new request wins over the clear-on-service so nothing is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (!w_id_ok) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end else if (r_state == c_IDLE) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_byte    <= 8'h00;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_bit_cnt <= '0;
          r_bit_idx <= 3'd0;
          if (r_pending && w_id_ok) begin
            r_state <= c_START;
            r_byte  <= {4'hA, ~board_id, board_id};
          end
        end
        c_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= c_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
          end
        end
        c_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= c_STOP;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
          end
        end
        c_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= c_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state   <= c_IDLE;
          r_bit_cnt <= '0;
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  // Line outputs trail the FSM by one cycle; frame_done marks the cycle busy drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_tx         <= w_tx_next;
      r_busy       <= (r_state != c_IDLE);
      r_frame_done <= r_busy && (r_state == c_IDLE);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_id_beacon_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_beacon_tx : directed self-checking bench for id_beacon_tx    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_id_beacon_tx;

  localparam int c_CPB = 4;
  localparam int c_PER = 200;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [1:0] board_id   = 2'b00;
  logic       id_valid   = 1'b0;
  logic       force_send = 1'b0;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_beacon_tx #(
    .CLKS_PER_BIT (c_CPB),
    .BEACON_PERIOD(c_PER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .board_id  (board_id),
    .id_valid  (id_valid),
    .force_send(force_send),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles and returns how many of them showed busy high or tx low.
  task automatic idle_run(input int n, output int activity);
    activity = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy || !tx) activity++;
    end
  endtask

  // Entered on the first busy cycle of a frame; checks len cycles of the line.
  task automatic check_frame(input string tag, input logic [7:0] b, input int len,
                             input logic [39:0] force_mask, input int drop_at);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < len; i++) begin
      check({tag, "_tx"}, {31'd0, tx}, {31'd0, f[i / c_CPB]});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      force_send = force_mask[i];
      if (i == drop_at) id_valid = 1'b0;
      step();
      force_send = 1'b0;
    end
    if (len == 10 * c_CPB) begin
      check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_end_done"}, {31'd0, frame_done}, 32'd1);
      check({tag, "_end_tx"}, {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    int         act;
    int         t;
    int         nstart;
    int         starts[8];
    logic       prev;
    logic [39:0] m;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    step();

    // Lock beacon for id 01: byte A9, start bit two edges after the request edge
    board_id = 2'b01;
    id_valid = 1'b1;
    step();
    check("t1_lat0_busy", {31'd0, busy}, 32'd0);
    step();
    check("t1_lat1_busy", {31'd0, busy}, 32'd0);
    check("t1_lat1_tx", {31'd0, tx}, 32'd1);
    step();
    check_frame("t1", 8'hA9, 40, '0, -1);
    step();
    check("t1_done_once", {31'd0, frame_done}, 32'd0);
    check("t1_no_more", {31'd0, busy}, 32'd0);
    id_valid = 1'b0;
    idle_run(20, act);
    check("t1_quiet", act, 0);

    // Three force_send pulses during a frame coalesce into one extra frame
    board_id = 2'b10;
    id_valid = 1'b1;
    step();
    step();
    step();
    m = '0;
    m[5] = 1'b1;
    m[17] = 1'b1;
    m[30] = 1'b1;
    check_frame("t2a", 8'hA6, 40, m, -1);
    step();
    check_frame("t2b", 8'hA6, 40, '0, -1);
    idle_run(60, act);
    check("t2_no_third", act, 0);
    id_valid = 1'b0;
    idle_run(10, act);

    // Periodic beacons every 200 cycles after the lock beacon, id 11 -> A3
    board_id = 2'b11;
    id_valid = 1'b1;
    step();
    step();
    step();
    t = 3;
    nstart = 1;
    starts[0] = 3;
    check_frame("t3", 8'hA3, 40, '0, -1);
    t = 43;
    prev = busy;
    while (t < 1006) begin
      step();
      t++;
      if (busy && !prev) begin
        if (nstart < 8) starts[nstart] = t;
        nstart++;
      end
      prev = busy;
    end
    check("t3_count", nstart, 6);
    for (int k = 1; k < 6; k++) begin
      if (k < nstart) check($sformatf("t3_gap%0d", k), starts[k] - starts[k-1], c_PER);
    end
    id_valid = 1'b0;
    idle_run(60, act);
    check("t3_idle_busy", {31'd0, busy}, 32'd0);

    // Unassigned id: nothing on the line, force_send ignored
    board_id = 2'b00;
    id_valid = 1'b1;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      force_send = (i == 10) || (i == 20);
      step();
      force_send = 1'b0;
      if (busy || !tx) act++;
    end
    check("t4_id00_quiet", act, 0);
    id_valid = 1'b0;
    board_id = 2'b01;
    step();
    force_send = 1'b1;
    step();
    force_send = 1'b0;
    idle_run(20, act);
    check("t4_force_lowvalid", act, 0);

    // id_valid dropped mid-frame: frame completes, no further beacons
    id_valid = 1'b1;
    step();
    step();
    step();
    check_frame("t5", 8'hA9, 40, '0, 14);
    idle_run(2 * c_PER, act);
    check("t5_no_follow", act, 0);

    // Reset during DATA, then only a fresh request restarts beaconing
    board_id = 2'b10;
    id_valid = 1'b1;
    step();
    step();
    step();
    check_frame("t6", 8'hA6, 14, '0, -1);
    rst_n = 1'b0;
    id_valid = 1'b0;
    step();
    check("t6_rst_tx", {31'd0, tx}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_run(10, act);
    force_send = 1'b1;
    step();
    force_send = 1'b0;
    idle_run(30, act);
    check("t6_post_rst_quiet", act, 0);
    id_valid = 1'b1;
    step();
    step();
    step();
    check_frame("t6_fresh", 8'hA6, 40, '0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
